shift_seq_monitor: RTL and testbench

//   Sits downstream of the 4-bit universal shift register and samples its parallel outputs {QA,QB,QC,QD}.

---
 rtl/shift_seq_monitor_pkg.sv | 23 ++
 rtl/shift_seq_monitor_if.sv | 28 ++
 rtl/shift_seq_monitor_seq_table.sv | 24 ++
 rtl/shift_seq_monitor.sv | 151 +++++++++++++++
 tb/tb_shift_seq_monitor.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_monitor_pkg.sv
// Shared types, default sizing and helpers for the shift-register sequence monitor.
package shift_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEARN = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_MAX_PERIOD = 16;
  localparam int DEF_ERR_LIMIT  = 2;
  localparam int DEF_CNT_W      = 8;

  localparam int IDX_W = $clog2(DEF_MAX_PERIOD);
  localparam int PER_W = IDX_W + 1;

  // Increment that sticks at max_v instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

endpackage

// File: rtl/shift_seq_monitor_if.sv
// Sample stream from the shift register plus the monitor's status outputs.
interface shift_mon_if
  import shift_mon_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CNT_W      = DEF_CNT_W
);

  logic [WIDTH-1:0] q_in;
  logic             q_valid;
  logic             locked;
  logic [PER_W-1:0] period;
  logic [IDX_W-1:0] seq_idx;
  logic             mismatch;
  logic             overflow;
  logic [CNT_W-1:0] err_count;

  modport master (
    output q_in, q_valid,
    input  locked, period, seq_idx, mismatch, overflow, err_count
  );

  modport slave (
    input  q_in, q_valid,
    output locked, period, seq_idx, mismatch, overflow, err_count
  );

endinterface

// File: rtl/shift_seq_monitor_seq_table.sv
// Learned-sequence storage: one synchronous write port, one combinational read port.
module seq_table #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/shift_seq_monitor.sv
// Learns the repeating pattern of a 4-bit shift register, then locks and checks each new sample.
module shift_seq_monitor
  import shift_mon_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int ERR_LIMIT  = DEF_ERR_LIMIT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       CLR,
  shift_mon_if.slave mon
);

  localparam int          RUN_W   = $clog2(ERR_LIMIT + 1);
  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  state_t           state, state_n;
  logic [WIDTH-1:0] anchor, anchor_n;
  logic [PER_W-1:0] len, len_n;
  logic [RUN_W-1:0] run, run_n, run_inc;
  logic             locked_r, locked_n;
  logic [PER_W-1:0] period_r, period_n;
  logic [IDX_W-1:0] idx_r, idx_n, nxt_idx;
  logic             mm_r, mm_n;
  logic             ovf_r, ovf_n;
  logic [CNT_W-1:0] err_r, err_n;

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  // Wrap by comparing against the learned period, avoiding a modulo.
  assign nxt_idx = (({1'b0, idx_r} + PER_W'(1)) == period_r) ? '0 : idx_r + IDX_W'(1);
  assign run_inc = run + RUN_W'(1);

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_PERIOD)
  ) u_table (
    .clk   (clk),
    .we    (we & ~CLR),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (nxt_idx),
    .rdata (rdata)
  );

  always_comb begin
    state_n  = state;
    anchor_n = anchor;
    len_n    = len;
    run_n    = run;
    locked_n = locked_r;
    period_n = period_r;
    idx_n    = idx_r;
    mm_n     = 1'b0;
    ovf_n    = ovf_r;
    err_n    = err_r;
    we       = 1'b0;
    waddr    = '0;
    wdata    = mon.q_in;

    if (mon.q_valid) begin
      case (state)
        IDLE: begin
          anchor_n = mon.q_in;
          we       = 1'b1;
          len_n    = PER_W'(1);
          state_n  = LEARN;
        end
        LEARN: begin
          if (mon.q_in == anchor) begin
            period_n = len;
            idx_n    = '0;
            locked_n = 1'b1;
            ovf_n    = 1'b0;
            run_n    = '0;
            state_n  = CHECK;
          end else if (len == PER_W'(MAX_PERIOD)) begin
            ovf_n    = 1'b1;
            anchor_n = mon.q_in;
            we       = 1'b1;
            len_n    = PER_W'(1);
          end else begin
            we    = 1'b1;
            waddr = len[IDX_W-1:0];
            len_n = len + PER_W'(1);
          end
        end
        CHECK: begin
          idx_n = nxt_idx;
          if (mon.q_in == rdata) begin
            run_n = '0;
          end else begin
            mm_n  = 1'b1;
            err_n = CNT_W'(sat_inc(int'(err_r), CNT_MAX));
            run_n = run_inc;
            // Too many back-to-back misses: treat this sample as the new anchor.
            if (run_inc == RUN_W'(ERR_LIMIT)) begin
              locked_n = 1'b0;
              period_n = '0;
              idx_n    = '0;
              run_n    = '0;
              anchor_n = mon.q_in;
              we       = 1'b1;
              len_n    = PER_W'(1);
              state_n  = LEARN;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      state    <= IDLE;
      anchor   <= '0;
      len      <= '0;
      run      <= '0;
      locked_r <= 1'b0;
      period_r <= '0;
      idx_r    <= '0;
      mm_r     <= 1'b0;
      ovf_r    <= 1'b0;
      err_r    <= '0;
    end else begin
      state    <= state_n;
      anchor   <= anchor_n;
      len      <= len_n;
      run      <= run_n;
      locked_r <= locked_n;
      period_r <= period_n;
      idx_r    <= idx_n;
      mm_r     <= mm_n;
      ovf_r    <= ovf_n;
      err_r    <= err_n;
    end
  end

  assign mon.locked    = locked_r;
  assign mon.period    = period_r;
  assign mon.seq_idx   = idx_r;
  assign mon.mismatch  = mm_r;
  assign mon.overflow  = ovf_r;
  assign mon.err_count = err_r;

endmodule

// File: tb/tb_shift_seq_monitor.sv
// Scoreboard bench for shift_seq_monitor: a queue-based reference model predicts every cycle's outputs.
module tb_shift_seq_monitor;

  localparam int MAXP = 16;
  localparam int ERRL = 2;

  typedef struct {
    int locked;
    int period;
    int idx;
    int mm;
    int ovf;
    int err;
  } exp_t;

  logic clk = 1'b0;
  logic CLR = 1'b0;

  shift_mon_if mon_if ();

  shift_seq_monitor dut (
    .clk (clk),
    .CLR (CLR),
    .mon (mon_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  int m_state = 0;
  logic [3:0] m_seq[$];
  int m_locked = 0, m_period = 0, m_idx = 0, m_mm = 0, m_ovf = 0, m_err = 0, m_run = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Independent reference: the learned loop is kept as a queue, index wraps by modulo.
  task automatic modelStep(input logic clr, input logic v, input logic [3:0] q);
    int n;
    m_mm = 0;
    if (clr) begin
      m_state = 0; m_seq.delete(); m_locked = 0; m_period = 0; m_idx = 0;
      m_ovf = 0; m_err = 0; m_run = 0;
    end else if (v) begin
      case (m_state)
        0: begin m_seq.delete(); m_seq.push_back(q); m_state = 1; end
        1: begin
          if (q == m_seq[0]) begin
            m_period = m_seq.size(); m_idx = 0; m_locked = 1; m_ovf = 0; m_run = 0; m_state = 2;
          end else if (m_seq.size() == MAXP) begin
            m_ovf = 1; m_seq.delete(); m_seq.push_back(q);
          end else begin
            m_seq.push_back(q);
          end
        end
        default: begin
          n = (m_idx + 1) % m_period;
          m_idx = n;
          if (q == m_seq[n]) begin
            m_run = 0;
          end else begin
            m_mm = 1;
            if (m_err < 255) m_err++;
            m_run++;
            if (m_run >= ERRL) begin
              m_locked = 0; m_period = 0; m_idx = 0; m_run = 0;
              m_seq.delete(); m_seq.push_back(q); m_state = 1;
            end
          end
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic v, input logic [3:0] q);
    exp_t e;
    @(negedge clk);
    CLR = clr;
    mon_if.q_valid = v;
    mon_if.q_in = q;
    modelStep(clr, v, q);
    e.locked = m_locked; e.period = m_period; e.idx = m_idx;
    e.mm = m_mm; e.ovf = m_ovf; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("locked",    32'(mon_if.locked),    32'(e.locked));
      checkOutput("period",    32'(mon_if.period),    32'(e.period));
      checkOutput("seq_idx",   32'(mon_if.seq_idx),   32'(e.idx));
      checkOutput("mismatch",  32'(mon_if.mismatch),  32'(e.mm));
      checkOutput("overflow",  32'(mon_if.overflow),  32'(e.ovf));
      checkOutput("err_count", 32'(mon_if.err_count), 32'(e.err));
    end
  endtask

  task automatic sample(input logic [3:0] q);
    applyStimulus(1'b0, 1'b1, q);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 4'h0);
  endtask

  logic [3:0] ring[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] john[8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                          4'b1111, 4'b0111, 4'b0011, 4'b0001};

  initial begin
    mon_if.q_in = 4'h0;
    mon_if.q_valid = 1'b0;
    doReset();
    doReset();
    checkOutput("reset_locked", 32'(mon_if.locked), 32'd0);
    checkOutput("reset_err", 32'(mon_if.err_count), 32'd0);

    // Ring with idle gaps; lock on the 5th sample.
    for (int i = 0; i < 5; i++) begin
      sample(ring[i % 4]);
      if (i == 1) applyStimulus(1'b0, 1'b0, 4'hF);
    end
    checkOutput("ring_lock", 32'(mon_if.locked), 32'd1);
    checkOutput("ring_period", 32'(mon_if.period), 32'd4);
    sample(ring[1]);
    sample(4'b0110);
    checkOutput("glitch_mm", 32'(mon_if.mismatch), 32'd1);
    checkOutput("glitch_err", 32'(mon_if.err_count), 32'd1);
    checkOutput("glitch_locked", 32'(mon_if.locked), 32'd1);
    sample(ring[3]);
    checkOutput("after_glitch_mm", 32'(mon_if.mismatch), 32'd0);
    checkOutput("after_glitch_idx", 32'(mon_if.seq_idx), 32'd3);
    sample(ring[0]);

    // Loss of lock, then relearn on a 3-long loop anchored at 1111.
    sample(4'b1111);
    sample(4'b1111);
    checkOutput("loss_locked", 32'(mon_if.locked), 32'd0);
    checkOutput("loss_period", 32'(mon_if.period), 32'd0);
    checkOutput("loss_err", 32'(mon_if.err_count), 32'd3);
    sample(4'b1010);
    sample(4'b0101);
    sample(4'b1111);
    checkOutput("relock_period", 32'(mon_if.period), 32'd3);
    for (int i = 0; i < 6; i++) sample((i % 3 == 0) ? 4'b1010 : (i % 3 == 1) ? 4'b0101 : 4'b1111);

    // Johnson counter.
    doReset();
    for (int i = 0; i < 40; i++) begin
      sample(john[i % 8]);
      if (i == 8) checkOutput("john_period", 32'(mon_if.period), 32'd8);
    end
    checkOutput("john_err", 32'(mon_if.err_count), 32'd0);

    // Overflow: 16 distinct values then a 17th non-anchor sample.
    doReset();
    for (int i = 0; i < 16; i++) sample(4'(i));
    checkOutput("pre_ovf", 32'(mon_if.overflow), 32'd0);
    sample(4'b0001);
    checkOutput("ovf_set", 32'(mon_if.overflow), 32'd1);
    sample(4'b0010);
    sample(4'b0011);
    sample(4'b0001);
    checkOutput("ovf_relock", 32'(mon_if.period), 32'd3);
    checkOutput("ovf_clear", 32'(mon_if.overflow), 32'd0);

    // Reset mid-LEARN and mid-CHECK, with a valid sample present.
    doReset();
    sample(4'b0011);
    sample(4'b0110);
    applyStimulus(1'b1, 1'b1, 4'b0011);
    checkOutput("clr_learn_locked", 32'(mon_if.locked), 32'd0);
    for (int i = 0; i < 6; i++) sample(ring[i % 4]);
    sample(4'b1110);
    applyStimulus(1'b1, 1'b1, ring[2]);
    checkOutput("clr_check_period", 32'(mon_if.period), 32'd0);
    checkOutput("clr_check_err", 32'(mon_if.err_count), 32'd0);
    sample(4'b0101);
    sample(4'b0101);
    checkOutput("const_period", 32'(mon_if.period), 32'd1);
    for (int i = 0; i < 3; i++) sample(4'b0101);

    // Mostly-ring traffic with random gaps and glitches.
    doReset();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] q;
      q = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : ring[i % 4];
      applyStimulus(1'b0, ($urandom_range(0, 3) != 0), q);
    end

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
